// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
//   Byte-wide program-image load port of the instruction memory loader.
//
//   ld_start  host -> loader  one-cycle pulse, begins or restarts a load
//   ld_valid  host -> loader  ld_byte carries a valid stream byte
//   ld_byte   host -> loader  load stream byte
//   ld_ready  loader -> host  loader accepts a byte this cycle
//   ld_done   loader -> host  image verified, core released from reset
//   ld_err    loader -> host  last load failed (length or checksum)
//
//   master : image source (host / boot controller)
//   slave  : instr_mem_loader
// -----------------------------------------------------------------------------
interface instr_mem_loader_if;
   logic       ld_start;
   logic       ld_valid;
   logic [7:0] ld_byte;
   logic       ld_ready;
   logic       ld_done;
   logic       ld_err;

   modport master (
      output ld_start,
      output ld_valid,
      output ld_byte,
      input  ld_ready,
      input  ld_done,
      input  ld_err
   );

   modport slave (
      input  ld_start,
      input  ld_valid,
      input  ld_byte,
      output ld_ready,
      output ld_done,
      output ld_err
   );
endinterface

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Owns the instruction memory feeding the core wrapper. A program image is
//   streamed in over the byte-wide load port as:
//     4-byte little-endian word count N, 4*N data bytes (little-endian words),
//     1 checksum byte making the mod-256 sum of the data bytes plus itself 0.
//   The core is held in reset until a complete, verified image is resident.
//
//   Parameters
//     DEPTH_WORDS  memory depth in 32-bit words (power of two, >= 16)
//     BASE_ADDR    byte address mapped to word 0
//
//   Ports
//     clk         single clock, rising edge
//     reset       asynchronous, active-high reset
//     ld          load port (instr_mem_loader_if.slave)
//     core_reset  reset to the core wrapper, low only while running
//     pc          fetch byte address from the core
//     instr       instruction word for pc (combinational read)
// -----------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      reset,
   instr_mem_loader_if.slave         ld,
   output logic                      core_reset,
   input  logic [31:0]               pc,
   output logic [31:0]               instr
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [AW:0] ONE_W = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CHECK,
      RUN,
      ERR
   } state_t;

   state_t      state;
   logic [1:0]  bcnt;     // byte position within the current word
   logic [AW:0] wcnt;     // words written so far
   logic [AW:0] nwords;   // word count from the header
   logic [7:0]  sum;      // mod-256 sum of DATA bytes
   logic [23:0] shreg;    // bytes 0..2 of the word being assembled

   logic [31:0] mem [DEPTH_WORDS];

   // ---------------------------------------------------------------------
   // Byte acceptance and word assembly
   // ---------------------------------------------------------------------
   logic        accept;
   logic        last_byte;
   logic [31:0] full_word;
   logic [7:0]  cks_total;
   logic        mem_we;

   // A byte presented together with ld_start is dropped: the restart wins.
   assign accept    = ld.ld_valid && ld.ld_ready && !ld.ld_start;
   assign last_byte = (bcnt == 2'd3);
   assign full_word = {ld.ld_byte, shreg};
   assign cks_total = sum + ld.ld_byte;
   assign mem_we    = accept && (state == DATA) && last_byte;

   // ---------------------------------------------------------------------
   // Memory write port (contents survive reset and aborted loads)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wcnt[AW-1:0]] <= full_word;
      end
   end

   // ---------------------------------------------------------------------
   // Fetch read: combinational, returns old contents on a same-cycle write.
   // Misaligned or out-of-range fetches return 0 so the core traps.
   // ---------------------------------------------------------------------
   logic [31:0] fetch_idx;
   logic        fetch_ok;

   assign fetch_idx = (pc - BASE_ADDR) >> 2;
   assign fetch_ok  = (pc[1:0] == 2'b00) && (fetch_idx < 32'(DEPTH_WORDS));

   always_comb begin
      instr = '0;
      if (fetch_ok) begin
         instr = mem[fetch_idx[AW-1:0]];
      end
   end

   // ---------------------------------------------------------------------
   // Load FSM with registered status outputs. Every transition sets the
   // outputs of the state it enters, so they change on the same edge.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bcnt        <= '0;
         wcnt        <= '0;
         nwords      <= '0;
         sum         <= '0;
         shreg       <= '0;
         ld.ld_ready <= 1'b0;
         ld.ld_done  <= 1'b0;
         ld.ld_err   <= 1'b0;
         core_reset  <= 1'b1;
      end else if (ld.ld_start) begin
         // Start or restart from any state; memory is left untouched.
         state       <= LEN;
         bcnt        <= '0;
         wcnt        <= '0;
         sum         <= '0;
         shreg       <= '0;
         ld.ld_ready <= 1'b1;
         ld.ld_done  <= 1'b0;
         ld.ld_err   <= 1'b0;
         core_reset  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
            end

            LEN: begin
               if (accept) begin
                  if (last_byte) begin
                     bcnt <= '0;
                     if (full_word > 32'(DEPTH_WORDS)) begin
                        state       <= ERR;
                        ld.ld_ready <= 1'b0;
                        ld.ld_err   <= 1'b1;
                     end else if (full_word == '0) begin
                        state  <= CHECK;
                        nwords <= '0;
                     end else begin
                        state  <= DATA;
                        nwords <= full_word[AW:0];
                     end
                  end else begin
                     bcnt <= bcnt + 2'd1;
                     case (bcnt)
                        2'd0:    shreg[7:0]   <= ld.ld_byte;
                        2'd1:    shreg[15:8]  <= ld.ld_byte;
                        default: shreg[23:16] <= ld.ld_byte;
                     endcase
                  end
               end
            end

            DATA: begin
               if (accept) begin
                  sum <= cks_total;
                  if (last_byte) begin
                     // The memory write of this word happens on this edge.
                     bcnt <= '0;
                     wcnt <= wcnt + ONE_W;
                     if (wcnt + ONE_W == nwords) begin
                        state <= CHECK;
                     end
                  end else begin
                     bcnt <= bcnt + 2'd1;
                     case (bcnt)
                        2'd0:    shreg[7:0]   <= ld.ld_byte;
                        2'd1:    shreg[15:8]  <= ld.ld_byte;
                        default: shreg[23:16] <= ld.ld_byte;
                     endcase
                  end
               end
            end

            CHECK: begin
               if (accept) begin
                  ld.ld_ready <= 1'b0;
                  if (cks_total == 8'h00) begin
                     state      <= RUN;
                     ld.ld_done <= 1'b1;
                     core_reset <= 1'b0;
                  end else begin
                     state     <= ERR;
                     ld.ld_err <= 1'b1;
                  end
               end
            end

            RUN: begin
            end

            ERR: begin
            end

            default: begin
               state       <= IDLE;
               ld.ld_ready <= 1'b0;
               ld.ld_done  <= 1'b0;
               ld.ld_err   <= 1'b0;
               core_reset  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Self-checking bench for instr_mem_loader (DEPTH_WORDS=16, BASE=0x1000).
//   Image words are pushed to a scoreboard as they are streamed and popped and
//   compared through the fetch port once the loader reports RUN; boundary
//   fetches come from a vector table.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

   localparam int unsigned DW   = 16;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        core_reset;
   logic [31:0] pc;
   logic [31:0] instr;

   instr_mem_loader_if lif ();

   instr_mem_loader #(
      .DEPTH_WORDS (DW),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ld         (lif),
      .core_reset (core_reset),
      .pc         (pc),
      .instr      (instr)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   bit mon_en  = 1'b0;
   bit mon_bad = 1'b0;
   always @(negedge clk) begin
      if (mon_en && core_reset !== 1'b1) mon_bad <= 1'b1;
   end

   typedef struct {
      int unsigned idx;
      logic [31:0] word;
   } sb_t;
   sb_t sb [$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp;
      string       name;
   } fetch_vec_t;
   fetch_vec_t tv [7];

   logic [31:0] img [32];
   int unsigned first_acc;
   int unsigned last_acc;

   function automatic logic [31:0] word_of(input int unsigned w);
      return {8'hC0 + 8'(w), 8'h5A, 8'(w), 8'h3C};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      lif.ld_start = 1'b1;
      tick();
      lif.ld_start = 1'b0;
   endtask

   // Present one byte until accepted, then idle ld_valid for gap cycles.
   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      int unsigned guard = 0;
      lif.ld_valid = 1'b1;
      lif.ld_byte  = b;
      while (lif.ld_ready !== 1'b1 && guard < 64) begin
         tick();
         guard++;
      end
      if (guard >= 64) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: ld_ready=%b, expected 1", lif.ld_ready);
      end
      tick();
      last_acc     = cyc;
      lif.ld_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_header(input logic [31:0] n, input int unsigned gap);
      for (int k = 0; k < 4; k++) begin
         send_byte(n[8*k +: 8], gap);
         if (k == 0) first_acc = last_acc;
      end
   endtask

   task automatic send_body(input int unsigned n, input int unsigned gap,
                            input logic [7:0] cks_adj, input bit push);
      logic [7:0] s;
      logic [7:0] c;
      logic [31:0] w32;
      s = 8'h00;
      send_header(n, gap);
      for (int w = 0; w < int'(n); w++) begin
         w32 = img[w];
         for (int k = 0; k < 4; k++) begin
            send_byte(w32[8*k +: 8], gap);
            s = s + w32[8*k +: 8];
         end
         if (push) sb.push_back('{idx: w, word: w32});
      end
      check("cr_before_cks", {31'd0, core_reset}, 32'd1);
      mon_en = 1'b0;
      c = 8'h00 - s;
      c = c + cks_adj;
      send_byte(c, gap);
   endtask

   task automatic drain_sb();
      sb_t e;
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         pc = BASE + 32'(4 * e.idx);
         #1;
         check($sformatf("sb_word%0d", e.idx), instr, e.word);
      end
   endtask

   task automatic check_status(input string tag, input logic rdy, input logic done,
                               input logic err, input logic cr);
      check({tag, "_ready"}, {31'd0, lif.ld_ready}, {31'd0, rdy});
      check({tag, "_done"},  {31'd0, lif.ld_done},  {31'd0, done});
      check({tag, "_err"},   {31'd0, lif.ld_err},   {31'd0, err});
      check({tag, "_corerst"}, {31'd0, core_reset}, {31'd0, cr});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{pc: BASE,                  exp: word_of(0),      name: "t_first"};
      tv[1] = '{pc: BASE + 32'(4*(DW-1)),  exp: word_of(DW-1),   name: "t_last"};
      tv[2] = '{pc: BASE + 32'd20,         exp: word_of(5),      name: "t_mid"};
      tv[3] = '{pc: BASE + 32'd2,          exp: 32'h0000_0000,   name: "t_misalign2"};
      tv[4] = '{pc: BASE + 32'd1,          exp: 32'h0000_0000,   name: "t_misalign1"};
      tv[5] = '{pc: BASE + 32'(4*DW),      exp: 32'h0000_0000,   name: "t_past_end"};
      tv[6] = '{pc: BASE - 32'd4,          exp: 32'h0000_0000,   name: "t_below_base"};

      lif.ld_start = 1'b0;
      lif.ld_valid = 1'b0;
      lif.ld_byte  = 8'h00;
      pc           = BASE;

      // Reset values
      #12;
      check_status("rst", 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      tick();

      // Good N=2 load at 1 byte/cycle
      img[0] = 32'h0000_0013;
      img[1] = 32'h0010_0093;
      pulse_start();
      check_status("start", 1'b1, 1'b0, 1'b0, 1'b1);
      send_body(2, 0, 8'h00, 1'b1);
      check("lat13", last_acc - first_acc, 32'd12);
      check_status("run1", 1'b0, 1'b1, 1'b0, 1'b0);
      pc = BASE + 32'd4;
      #1;
      check("fetch_base4", instr, 32'h0010_0093);
      drain_sb();

      // ld_valid in RUN is ignored
      lif.ld_valid = 1'b1;
      lif.ld_byte  = 8'h55;
      repeat (3) tick();
      lif.ld_valid = 1'b0;
      check_status("run_valid", 1'b0, 1'b1, 1'b0, 1'b0);

      // Restart from RUN, then bad checksum
      pulse_start();
      check_status("restart_run", 1'b1, 1'b0, 1'b0, 1'b1);
      send_body(2, 0, 8'h01, 1'b0);
      check_status("bad_cks", 1'b0, 1'b0, 1'b1, 1'b1);
      lif.ld_valid = 1'b1;
      repeat (3) tick();
      lif.ld_valid = 1'b0;
      check_status("err_hold", 1'b0, 1'b0, 1'b1, 1'b1);
      pulse_start();
      check_status("err_restart", 1'b1, 1'b0, 1'b0, 1'b1);
      send_body(2, 0, 8'h00, 1'b1);
      check_status("run2", 1'b0, 1'b1, 1'b0, 1'b0);
      drain_sb();

      // Length too large: error right after the 4th header byte
      pulse_start();
      send_header(DW + 1, 0);
      check_status("len_big", 1'b0, 1'b0, 1'b1, 1'b1);

      // N=0 with checksum 0x00
      pulse_start();
      send_body(0, 0, 8'h00, 1'b0);
      check_status("len_zero", 1'b0, 1'b1, 1'b0, 1'b0);

      // Throttled load aborted mid-DATA, byte dropped with ld_start, reload
      for (int w = 0; w < 4; w++) img[w] = 32'hAAAA_0000 + 32'(w);
      pulse_start();
      send_header(4, 2);
      for (int w = 0; w < 2; w++)
         for (int k = 0; k < 4; k++) send_byte(8'(img[w] >> (8*k)), 2);
      send_byte(8'h11, 2);
      send_byte(8'h22, 2);
      lif.ld_valid = 1'b1;
      lif.ld_byte  = 8'hFF;
      lif.ld_start = 1'b1;
      tick();
      lif.ld_start = 1'b0;
      lif.ld_valid = 1'b0;
      mon_en = 1'b1;
      check_status("abort", 1'b1, 1'b0, 1'b0, 1'b1);
      for (int w = 0; w < 3; w++) img[w] = 32'hBEEF_0000 | 32'(w * 32'h111);
      send_body(3, 2, 8'h00, 1'b1);
      check_status("reload", 1'b0, 1'b1, 1'b0, 1'b0);
      check("cr_held_reload", {31'd0, mon_bad}, 32'd0);
      drain_sb();

      // Full-depth load, then fetch boundary table
      for (int w = 0; w < int'(DW); w++) img[w] = word_of(w);
      pulse_start();
      send_body(DW, 0, 8'h00, 1'b1);
      check_status("run_full", 1'b0, 1'b1, 1'b0, 1'b0);
      drain_sb();
      for (int i = 0; i < 7; i++) begin
         pc = tv[i].pc;
         #1;
         check(tv[i].name, instr, tv[i].exp);
      end

      // Asynchronous reset mid-DATA takes effect between clock edges
      pulse_start();
      send_header(2, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      check_status("pre_arst", 1'b1, 1'b0, 1'b0, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_status("arst", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      reset = 1'b0;
      tick();
      check_status("post_arst", 1'b0, 1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
